// File: rtl/hilo_pair_unit.sv
// HI/LO special-register pair: independent bus loads per half, atomic timed
// multiply/divide commit of both halves, busy/stall interlock and sticky conflict flag.
module hilo_pair_unit #(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    MUL_LATENCY = 4,
  parameter int                    DIV_LATENCY = 8,
  parameter logic [DATA_WIDTH-1:0] INIT_HI     = {DATA_WIDTH{1'b0}},
  parameter logic [DATA_WIDTH-1:0] INIT_LO     = {DATA_WIDTH{1'b0}}
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  HIin,
  input  logic                  LOin,
  input  logic [DATA_WIDTH-1:0] BusMuxOut,
  input  logic                  start_mul,
  input  logic                  start_div,
  input  logic [DATA_WIDTH-1:0] alu_hi,
  input  logic [DATA_WIDTH-1:0] alu_lo,
  input  logic                  HIout,
  input  logic                  LOout,
  output logic [DATA_WIDTH-1:0] BusMuxInHI,
  output logic [DATA_WIDTH-1:0] BusMuxInLO,
  output logic                  busy,
  output logic                  done,
  output logic                  stall,
  output logic                  wr_conflict
);

  localparam int MAX_LAT = (MUL_LATENCY > DIV_LATENCY) ? MUL_LATENCY : DIV_LATENCY;
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] MUL_CNT  = CNT_W'(MUL_LATENCY - 1);
  localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_LATENCY - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] hi_q, hi_d;
  logic [DATA_WIDTH-1:0] lo_q, lo_d;
  logic [DATA_WIDTH-1:0] pend_hi_q, pend_hi_d;
  logic [DATA_WIDTH-1:0] pend_lo_q, pend_lo_d;
  logic                  done_q, done_d;
  logic                  conf_q, conf_d;

  // State, counter, register pair, pending result and flags.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q   <= IDLE;
      cnt_q     <= CNT_ZERO;
      hi_q      <= INIT_HI;
      lo_q      <= INIT_LO;
      pend_hi_q <= {DATA_WIDTH{1'b0}};
      pend_lo_q <= {DATA_WIDTH{1'b0}};
      done_q    <= 1'b0;
      conf_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      done_q    <= done_d;
      conf_q    <= conf_d;
    end
  end

  // Next-state: bus loads and start capture in IDLE, countdown and commit in RUN.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    done_d    = 1'b0;
    conf_d    = conf_q;

    case (state_q)
      IDLE: begin
        if (HIin) begin
          hi_d = BusMuxOut;
        end else begin
          hi_d = hi_q;
        end
        if (LOin) begin
          lo_d = BusMuxOut;
        end else begin
          lo_d = lo_q;
        end
        // Multiply has priority; a simultaneous divide request is a conflict.
        if (start_mul) begin
          pend_hi_d = alu_hi;
          pend_lo_d = alu_lo;
          cnt_d     = MUL_CNT;
          state_d   = RUN;
          if (start_div) begin
            conf_d = 1'b1;
          end else begin
            conf_d = conf_q;
          end
        end else if (start_div) begin
          pend_hi_d = alu_hi;
          pend_lo_d = alu_lo;
          cnt_d     = DIV_CNT;
          state_d   = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (HIin || LOin || start_mul || start_div) begin
          conf_d = 1'b1;
        end else begin
          conf_d = conf_q;
        end
        if (cnt_q == CNT_ZERO) begin
          hi_d    = pend_hi_q;
          lo_d    = pend_lo_q;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign BusMuxInHI  = hi_q;
  assign BusMuxInLO  = lo_q;
  assign busy        = (state_q == RUN);
  assign stall       = busy & (HIout | LOout);
  assign done        = done_q;
  assign wr_conflict = conf_q;

endmodule
